// File: rtl/clic_gateway.sv
// clic_gateway: per-source interrupt gateway for a CLIC.
// Each raw line is synchronized and polarity-corrected. It is then either
// copied straight through (level mode) or latched as a pending bit that
// software sets and clears, or that an ack clears (edge mode). In edge mode a
// sticky overflow flag records edges that arrived while the source was
// already pending. All outputs come straight from flops.
module clic_gateway #(
    parameter int N_SOURCE    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int IDW         = $clog2(N_SOURCE)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] intr_src_i,
    input  logic [N_SOURCE-1:0] le_i,
    input  logic [N_SOURCE-1:0] pol_i,
    input  logic [N_SOURCE-1:0] sw_set_i,
    input  logic [N_SOURCE-1:0] sw_clr_i,
    input  logic                ack_valid_i,
    input  logic [IDW-1:0]      ack_id_i,
    output logic [N_SOURCE-1:0] ip_o,
    output logic [N_SOURCE-1:0] ovf_o
);

    genvar gi;
    generate
        for (gi = 0; gi < N_SOURCE; gi++) begin : g_src
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;
            logic                   le_reg;
            logic                   ip_reg;
            logic                   ovf_reg;
            logic                   ip_next;
            logic                   ovf_next;
            logic                   s_act;
            logic                   edge_det;
            logic                   ack_hit;
            logic                   mode_chg;

            // Active level after the synchronizer, corrected for polarity.
            // A polarity change therefore looks like an ordinary edge.
            assign s_act    = sync_reg[SYNC_STAGES-1] ^ pol_i[gi];
            assign edge_det = s_act & ~prev_reg;
            // The 32-bit compare keeps an out-of-range ID from aliasing onto
            // a real source.
            assign ack_hit  = ack_valid_i && (32'(ack_id_i) == gi);
            assign mode_chg = le_i[gi] ^ le_reg;

            // Synchronizer, edge history and the previous mode. prev_reg
            // tracks in both modes, so a mode switch never fakes an edge.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync_reg <= '0;
                    prev_reg <= 1'b0;
                    le_reg   <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], intr_src_i[gi]};
                    prev_reg <= s_act;
                    le_reg   <= le_i[gi];
                end
            end

            // Next pending/overflow state. In the edge-mode update, a set
            // beats a clear in the same cycle so that no new edge is lost.
            always_comb begin
                ip_next  = ip_reg;
                ovf_next = ovf_reg;
                if (mode_chg) begin
                    ip_next  = le_i[gi] ? 1'b0 : s_act;
                    ovf_next = 1'b0;
                end else if (le_i[gi]) begin
                    if (edge_det || sw_set_i[gi]) begin
                        ip_next = 1'b1;
                    end else if (sw_clr_i[gi] || ack_hit) begin
                        ip_next = 1'b0;
                    end
                    if (sw_clr_i[gi]) begin
                        ovf_next = 1'b0;
                    end else if (edge_det && ip_reg && !ack_hit) begin
                        ovf_next = 1'b1;
                    end
                end else begin
                    ip_next = s_act;
                end
            end

            // Pending and overflow flops; they drive the outputs directly.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ip_reg  <= 1'b0;
                    ovf_reg <= 1'b0;
                end else begin
                    ip_reg  <= ip_next;
                    ovf_reg <= ovf_next;
                end
            end

            assign ip_o[gi]  = ip_reg;
            assign ovf_o[gi] = ovf_reg;
        end
    endgenerate

endmodule
